// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   rx_state_e : receiver FSM states
//   DATA_BITS  : payload bits per frame (8N1)
//   MIN_DIV    : smallest usable clocks-per-bit value
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned MIN_DIV   = 4;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous input pins.
//   clk     : destination clock
//   resetn  : asynchronous active-low reset
//   rst_val : value both flops take during reset (tie to the pin's idle level)
//   d       : asynchronous input
//   q       : synchronized output, two clocks of latency
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta_q <= rst_val;
            sync_q <= rst_val;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver, LSB first, run-time bit period.
//   clk         : system clock (rising edge)
//   resetn      : asynchronous active-low reset
//   ser_rx      : serial line, idle high, asynchronous to clk
//   cfg_divider : clocks per bit, captured at each accepted start edge
//   data        : last correctly framed byte
//   valid       : single-cycle strobe when data has just been updated
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ser_rx,
    input  logic [DIV_W-1:0] cfg_divider,
    output logic [7:0]       data,
    output logic             valid
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_e            state_q, state_d;
    logic [DIV_W-1:0]     cnt_q, cnt_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;

    logic [DIV_W-1:0]     div_eff;
    logic [DIV_W-1:0]     half_bit;
    logic [DIV_W-1:0]     last_cnt;

    sync_2ff #(
        .WIDTH(1)
    ) u_sync_rx (
        .clk    (clk),
        .resetn (resetn),
        .rst_val(1'b1),
        .d      (ser_rx),
        .q      (rx_s)
    );

    // Dividers below MIN_DIV leave no room between the mid-bit sample and the
    // bit boundary, so they are raised to MIN_DIV.
    assign div_eff  = (cfg_divider < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : cfg_divider;
    assign half_bit = div_q >> 1;
    assign last_cnt = div_q - DIV_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = '0;
                    div_d   = div_eff;
                    state_d = START;
                end
            end

            // Re-check the line half a bit in; a high line means the edge was noise.
            START: begin
                if (cnt_q == half_bit) begin
                    if (!rx_s) begin
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        state_d   = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            // Counting a full period from the mid-start sample keeps every
            // later sample centred in its bit.
            DATA: begin
                if (cnt_q == last_cnt) begin
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    cnt_d     = '0;
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            // Returning to IDLE at mid-stop leaves half a bit to catch a
            // back-to-back start edge.
            STOP: begin
                if (cnt_q == last_cnt) begin
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= DIV_W'(MIN_DIV);
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    assign data  = data_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed + randomized checks of uart_receiver.
// Reference model: every frame sent with a high stop bit (and not aborted)
// must produce exactly one valid pulse carrying that byte, in send order.
module tb_uart_receiver;

    localparam int unsigned DIV_W = 32;

    logic             clk = 1'b0;
    logic             resetn;
    logic             ser_rx;
    logic [DIV_W-1:0] cfg_divider;
    logic [7:0]       data;
    logic             valid;

    int unsigned checks     = 0;
    int unsigned failures   = 0;
    int unsigned cyc        = 0;
    int unsigned pulses     = 0;
    int unsigned good_sent  = 0;
    int unsigned last_pulse = 0;
    logic [7:0]  last_good  = 8'h00;
    logic [7:0]  exp_q[$];

    always #20 clk = ~clk;

    uart_receiver #(
        .DIV_W(DIV_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .ser_rx     (ser_rx),
        .cfg_divider(cfg_divider),
        .data       (data),
        .valid      (valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        logic [7:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (valid === 1'b1) begin
            pulses++;
            last_pulse = cyc;
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_valid observed data=0x%0h expected=no pulse", data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rx_data", {24'h0, data}, {24'h0, e});
                last_good = e;
            end
        end
    endtask

    task automatic idle(input int unsigned n);
        ser_rx = 1'b1;
        repeat (n) tick();
    endtask

    // Drives start, 8 data bits LSB first, stop. abort_bit >= 0 asserts reset
    // halfway through that data bit. mid_div != 0 changes cfg_divider right
    // after the start bit.
    task automatic send_frame(input logic [7:0] b, input int unsigned bit_clks,
                              input logic stop_v, input int abort_bit,
                              input logic [31:0] mid_div, output int unsigned start_cyc);
        logic [9:0] bits;
        bits = {stop_v, b, 1'b0};
        if (stop_v && abort_bit < 0) begin
            exp_q.push_back(b);
            good_sent++;
        end
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            ser_rx = bits[i];
            for (int unsigned k = 0; k < bit_clks; k++) begin
                if (abort_bit >= 0 && i == abort_bit + 1 && k == bit_clks / 2) begin
                    resetn = 1'b0;
                    ser_rx = 1'b1;
                    return;
                end
                tick();
            end
            if (i == 0 && mid_div != 0) cfg_divider = mid_div;
        end
        ser_rx = 1'b1;
    endtask

    initial begin
        int unsigned st;
        int unsigned lat;
        int unsigned d;
        logic        stop_v;

        resetn      = 1'b0;
        ser_rx      = 1'b1;
        cfg_divider = 217;

        // Reset held with a toggling line.
        for (int i = 0; i < 12; i++) begin
            ser_rx = 1'($urandom_range(0, 1));
            tick();
            chk("reset_data", {24'h0, data}, 32'h0);
            chk("reset_valid", {31'h0, valid}, 32'h0);
        end
        ser_rx = 1'b1;
        resetn = 1'b1;
        idle(300);
        chk("idle_no_pulse", pulses, 0);

        // Single byte; valid expected ~9.5 bit periods + 3 clocks after the edge.
        send_frame(8'h41, 217, 1'b1, -1, 0, st);
        idle(50);
        lat = last_pulse - st;
        chk("pulses_0x41", pulses, 1);
        chk("latency_0x41", {31'h0, (lat >= 2061 && lat <= 2069)}, 32'h1);

        // Bit order and back-to-back frames.
        send_frame(8'h01, 217, 1'b1, -1, 0, st);
        send_frame(8'h80, 217, 1'b1, -1, 0, st);
        send_frame(8'hFF, 217, 1'b1, -1, 0, st);
        idle(50);
        chk("pulses_b2b", pulses, 4);
        chk("data_b2b_last", {24'h0, data}, 32'hFF);

        // Glitch shorter than half a bit.
        ser_rx = 1'b0;
        repeat (50) tick();
        idle(400);
        chk("pulses_glitch", pulses, 4);
        send_frame(8'h55, 217, 1'b1, -1, 0, st);
        idle(50);
        chk("pulses_after_glitch", pulses, 5);

        // Framing error: byte dropped, data holds.
        send_frame(8'h3C, 217, 1'b0, -1, 0, st);
        idle(434);
        chk("pulses_frame_err", pulses, 5);
        chk("data_hold_frame_err", {24'h0, data}, {24'h0, last_good});
        send_frame(8'h7E, 217, 1'b1, -1, 0, st);
        idle(50);
        chk("pulses_after_frame_err", pulses, 6);

        // Reset during data bit 4.
        send_frame(8'hA5, 217, 1'b1, 4, 0, st);
        repeat (5) begin
            tick();
            chk("midreset_data", {24'h0, data}, 32'h0);
            chk("midreset_valid", {31'h0, valid}, 32'h0);
        end
        resetn = 1'b1;
        idle(500);
        chk("pulses_aborted", pulses, 6);
        send_frame(8'h5A, 217, 1'b1, -1, 0, st);
        idle(50);
        chk("pulses_after_abort", pulses, 7);

        // Divider changed mid-frame only affects the next frame.
        send_frame(8'hC3, 217, 1'b1, -1, 50, st);
        idle(50);
        chk("pulses_mid_div", pulses, 8);
        chk("data_mid_div", {24'h0, data}, 32'hC3);
        cfg_divider = 217;

        // Dividers below the minimum behave as 4 clocks per bit.
        for (int i = 0; i < 4; i++) begin
            cfg_divider = $urandom_range(0, 3);
            send_frame(8'($urandom), 4, 1'b1, -1, 0, st);
        end
        idle(20);
        chk("pulses_clamp", pulses, good_sent);

        // Random bytes, dividers, gaps and occasional framing errors.
        for (int i = 0; i < 24; i++) begin
            d           = $urandom_range(4, 40);
            cfg_divider = d;
            stop_v      = ($urandom_range(0, 4) != 0);
            send_frame(8'($urandom), d, stop_v, -1, 0, st);
            if (!stop_v) idle(2 * d);
            else idle($urandom_range(0, 2) * d);
        end
        idle(100);
        chk("pulses_random", pulses, good_sent);
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
